// File: rtl/protocore_uart_pkg.sv
// rtl/protocore_uart_pkg.sv - shared UART framing constants and dumper FSM encoding
package protocore_uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;

  // Same framing words the program loader recognises, sent MSB byte first.
  localparam logic [23:0] START_WORD = 24'h0000FF;
  localparam logic [23:0] STOP_WORD  = 24'h00F0FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_TRAILER,
    ST_DONE
  } dump_state_e;

  function automatic logic [7:0] word_byte(input logic [23:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    word_byte = word[23:16];
      2'd1:    word_byte = word[15:8];
      default: word_byte = word[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-level 8N1 UART transmitter with gapless back-to-back handshake
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_prefetch,
  output logic       UART_tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PREFETCH_AT = CNT_W'(CLKS_PER_BIT - 4);

  logic             active;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] baud_cnt;
  logic [7:0]       data_q;
  logic             stop_last;

  // bit_idx: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  assign stop_last   = active && (bit_idx == 4'd9) && (baud_cnt == CNT_MAX);
  assign tx_ready    = !active || stop_last;
  // Three cycles ahead of the stop-bit end, so a memory fetch can complete in time.
  assign tx_prefetch = active && (bit_idx == 4'd9) && (baud_cnt == PREFETCH_AT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active   <= 1'b0;
      bit_idx  <= 4'd0;
      baud_cnt <= '0;
      data_q   <= 8'h00;
    end else if (tx_valid && tx_ready) begin
      active   <= 1'b1;
      bit_idx  <= 4'd0;
      baud_cnt <= '0;
      data_q   <= tx_data;
    end else if (active) begin
      if (baud_cnt == CNT_MAX) begin
        baud_cnt <= '0;
        if (bit_idx >= 4'd1 && bit_idx <= 4'd8) begin
          data_q <= {1'b0, data_q[7:1]};
        end
        if (bit_idx == 4'd9) begin
          active  <= 1'b0;
          bit_idx <= 4'd0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    UART_tx = 1'b1;
    if (active) begin
      if (bit_idx == 4'd0) begin
        UART_tx = 1'b0;
      end else if (bit_idx != 4'd9) begin
        UART_tx = data_q[0];
      end
    end
  end

endmodule

// File: rtl/uart_prog_dumper.sv
// rtl/uart_prog_dumper.sv - streams instruction memory out over UART in loader framing
module uart_prog_dumper
  import protocore_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int ADDR_W       = 8,
  parameter int INSTR_W      = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  last_addr,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               UART_tx,
  output logic               busy,
  output logic               done
);

  dump_state_e        state, state_next;
  logic [ADDR_W-1:0]  last_q;
  logic [INSTR_W-1:0] sreg;
  logic [1:0]         byte_idx;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_prefetch;

  logic accept;
  logic byte_inc;
  logic byte_clr;
  logic addr_inc;
  logic cap_en;
  logic shift_en;

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_prefetch(tx_prefetch),
    .UART_tx    (UART_tx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // byte_idx == 3 means all three bytes of the group are handed to the transmitter.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    accept     = 1'b0;
    byte_inc   = 1'b0;
    byte_clr   = 1'b0;
    addr_inc   = 1'b0;
    cap_en     = 1'b0;
    shift_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        if (byte_idx != 2'd3) begin
          tx_valid = 1'b1;
          tx_data  = word_byte(START_WORD, byte_idx);
          byte_inc = tx_ready;
        end else if (tx_prefetch) begin
          byte_clr   = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: state_next = ST_LATCH;
      ST_LATCH: begin
        cap_en     = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (byte_idx != 2'd3) begin
          tx_valid = 1'b1;
          tx_data  = sreg[INSTR_W-1 -: 8];
          byte_inc = tx_ready;
          shift_en = tx_ready;
        end else if (tx_prefetch) begin
          byte_clr = 1'b1;
          // Compare before increment so the top address never wraps back to 0.
          if (mem_addr == last_q) begin
            state_next = ST_TRAILER;
          end else begin
            addr_inc   = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end
      ST_TRAILER: begin
        if (byte_idx != 2'd3) begin
          tx_valid = 1'b1;
          tx_data  = word_byte(STOP_WORD, byte_idx);
          byte_inc = tx_ready;
        end else if (tx_ready) begin
          byte_clr   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr <= '0;
      last_q   <= '0;
      sreg     <= '0;
      byte_idx <= 2'd0;
    end else begin
      if (accept) begin
        mem_addr <= '0;
        last_q   <= last_addr;
      end else if (addr_inc) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (cap_en) begin
        sreg <= mem_rdata;
      end else if (shift_en) begin
        sreg <= {sreg[INSTR_W-9:0], 8'h00};
      end
      if (accept || byte_clr) begin
        byte_idx <= 2'd0;
      end else if (byte_inc) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_uart_prog_dumper.sv
// tb/tb_uart_prog_dumper.sv - scoreboard bench: expected bytes queued, UART monitor decodes and compares
module tb_uart_prog_dumper;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  last_addr = 8'd0;
  logic [7:0]  mem_addr;
  logic [23:0] mem_rdata;
  logic        UART_tx;
  logic        busy;
  logic        done;

  logic [23:0] mem [256];
  logic [7:0]  exp_q [$];
  int          addr_log [$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart_prog_dumper #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (8),
    .INSTR_W     (24)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .last_addr(last_addr),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .UART_tx  (UART_tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // UART receive monitor and scoreboard
  bit         rx_act = 1'b0;
  bit         gap_ref = 1'b0;
  int         rx_k = 0;
  int         rx_bytes = 0;
  int         first_start = 0;
  int         last_start = 0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      rx_act = 1'b0;
      gap_ref = 1'b0;
      exp_q.delete();
    end else if (!rx_act) begin
      if (UART_tx === 1'b0) begin
        rx_act = 1'b1;
        rx_k = 0;
        if (gap_ref) chk("byte_gap", cyc - last_start, 10 * CPB);
        else first_start = cyc;
        last_start = cyc;
      end else if (!busy) begin
        gap_ref = 1'b0;
      end
    end else begin
      rx_k++;
      if (rx_k == CPB / 2) begin
        chk("start_bit", int'(UART_tx), 0);
      end else if (rx_k > CPB && rx_k < 9 * CPB && (rx_k % CPB) == CPB / 2) begin
        rx_sh = {UART_tx, rx_sh[7:1]};
      end else if (rx_k == 9 * CPB + CPB / 2) begin
        chk("stop_bit", int'(UART_tx), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_byte_unexpected: got 0x%02h expected no byte", rx_sh);
        end else begin
          chk("rx_byte", int'(rx_sh), int'(exp_q.pop_front()));
        end
        rx_bytes++;
        gap_ref = 1'b1;
        rx_act = 1'b0;
      end
    end
  end

  int   done_cnt = 0;
  int   done_cyc = 0;
  logic busy_prev = 1'b0;
  int   addr_prev = 0;

  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst && busy) begin
      if (!busy_prev) begin
        addr_log.delete();
        addr_log.push_back(int'(mem_addr));
      end else if (int'(mem_addr) != addr_prev) begin
        addr_log.push_back(int'(mem_addr));
      end
      addr_prev = int'(mem_addr);
    end
    busy_prev = rst && busy;
  end

  task automatic push_word(input logic [23:0] w);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic pulse_start(input logic [7:0] la);
    @(posedge clk);
    #1;
    last_addr = la;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_dump(input int la, input bit second_start, output int nbytes);
    int rx0;
    int dn0;
    int budget;
    rx0 = rx_bytes;
    dn0 = done_cnt;
    budget = (la + 4) * 30 * CPB + 200;
    pulse_start(8'(la));
    if (second_start) begin
      repeat (5 * CPB) @(posedge clk);
      pulse_start(8'd7);
    end
    while (done_cnt == dn0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (budget == 0) chk("done_timeout", 0, 1);
    repeat (2 * CPB) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt - dn0, 1);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("busy_after_done", int'(busy), 0);
    chk("tx_idle_after_done", int'(UART_tx), 1);
    nbytes = rx_bytes - rx0;
  endtask

  initial begin
    int n;
    int zeros;
    for (int i = 0; i < 256; i++) mem[i] = 24'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", int'(UART_tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(mem_addr), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // single word
    mem[0] = 24'h80010A;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    exp_q.push_back(8'h80); exp_q.push_back(8'h01); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h00); exp_q.push_back(8'hF0); exp_q.push_back(8'hFF);
    run_dump(0, 1'b0, n);
    chk("single_bytes", n, 9);
    chk("single_done_time", done_cyc - first_start, 90 * CPB);

    // two words
    mem[0] = 24'h003130;
    mem[1] = 24'hD400FD;
    push_word(24'h0000FF);
    exp_q.push_back(8'h00); exp_q.push_back(8'h31); exp_q.push_back(8'h30);
    exp_q.push_back(8'hD4); exp_q.push_back(8'h00); exp_q.push_back(8'hFD);
    push_word(24'h00F0FF);
    run_dump(1, 1'b0, n);
    chk("two_bytes", n, 12);
    chk("two_addr_len", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("two_addr0", addr_log[0], 0);
      chk("two_addr1", addr_log[1], 1);
    end

    // framing words as data go out verbatim
    mem[0] = 24'h0000FF;
    mem[1] = 24'h00F0FF;
    push_word(24'h0000FF);
    push_word(24'h0000FF);
    push_word(24'h00F0FF);
    push_word(24'h00F0FF);
    run_dump(1, 1'b0, n);
    chk("framing_data_bytes", n, 12);

    // busy guard: second start mid-header is ignored
    mem[0] = 24'h80010A;
    push_word(24'h0000FF);
    push_word(24'h80010A);
    push_word(24'h00F0FF);
    run_dump(0, 1'b1, n);
    chk("guard_bytes", n, 9);

    // reset during data bit 3 of the third header byte
    n = rx_bytes;
    push_word(24'h0000FF);
    push_word(24'h80010A);
    push_word(24'h00F0FF);
    pulse_start(8'd0);
    repeat (24 * CPB + 3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_tx", int'(UART_tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_addr", int'(mem_addr), 0);
    chk("midrst_bytes_before", rx_bytes - n, 2);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    mem[0] = 24'hA5C33C;
    push_word(24'h0000FF);
    push_word(24'hA5C33C);
    push_word(24'h00F0FF);
    run_dump(0, 1'b0, n);
    chk("post_rst_bytes", n, 9);

    // full memory
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'(i), 8'(i)};
    push_word(24'h0000FF);
    for (int i = 0; i < 256; i++) push_word({8'(i), 8'(i), 8'(i)});
    push_word(24'h00F0FF);
    run_dump(255, 1'b0, n);
    chk("full_bytes", n, 774);
    chk("full_addr_len", addr_log.size(), 256);
    zeros = 0;
    for (int i = 1; i < addr_log.size(); i++) if (addr_log[i] == 0) zeros++;
    chk("full_no_wrap", zeros, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
